// File: rtl/apb_slave_regif.sv
// apb_slave_regif: APB4 slave front-end issuing register strobes to a back-end register file
module apb_slave_regif #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 16,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int LSB        = $clog2(STRB_W),
    localparam int IDXW       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_W-1:0]     PSTRB,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  wr_en,
    output logic [IDXW-1:0]       wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [STRB_W-1:0]     wr_strb,
    output logic                  rd_en,
    output logic [IDXW-1:0]       rd_idx,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [CNT_W-1:0] WS_C    = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [ADDR_WIDTH:0] NREG_A = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [1:0]            state_q, state_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [IDXW-1:0]       wr_idx_q, wr_idx_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [STRB_W-1:0]     wr_strb_q, wr_strb_d;
    logic                  rd_en_q, rd_en_d;
    logic [IDXW-1:0]       rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [IDXW-1:0] idx;
    logic            addr_err;
    logic            setup;

    // Word index and out-of-range detection; the extra top bit keeps NUM_REGS representable
    assign idx      = PADDR[LSB+IDXW-1:LSB];
    assign addr_err = {1'b0, PADDR >> LSB} >= NREG_A;
    assign setup    = (state_q == S_IDLE) && PSEL && !PENABLE;

    // Next-state and output computation for the IDLE -> WAIT -> RESP transfer sequence
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
        rd_en_d   = 1'b0;
        rd_idx_d  = rd_idx_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    state_d = S_WAIT;
                    write_d = PWRITE;
                    err_d   = addr_err;
                    cnt_d   = '0;
                    if (PWRITE) begin
                        wr_idx_d  = idx;
                        wr_data_d = PWDATA;
                        wr_strb_d = PSTRB;
                        wr_en_d   = !addr_err && (|PSTRB);
                    end else begin
                        rd_idx_d = idx;
                        rd_en_d  = !addr_err;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (err_q) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else if (write_q && cnt_q == WS_C) begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                end else if (!write_q && rd_valid) begin
                    state_d  = S_RESP;
                    pready_d = 1'b1;
                    prdata_d = rd_data;
                end else if (!write_q && cnt_q == TO_C) begin
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: begin
                state_d   = S_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            rd_en_q   <= 1'b0;
            rd_idx_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
            rd_en_q   <= rd_en_d;
            rd_idx_q  <= rd_idx_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;
    assign wr_strb = wr_strb_q;
    assign rd_en   = rd_en_q;
    assign rd_idx  = rd_idx_q;
endmodule

// File: tb/tb_apb_slave_regif.sv
// tb_apb_slave_regif: scoreboard bench for apb_slave_regif (32-bit default and 16-bit/2-wait-state instances)
module tb_apb_slave_regif;
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;
    typedef struct {
        int          cyc;
        bit          wr;
        int          idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } stb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        PSEL = 1'b0;
    logic        PSEL16 = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [31:0] rd_data = '0;
    logic        rd_valid = 1'b0;

    logic [31:0] PRDATA, wr_data;
    logic        PREADY, PSLVERR, wr_en, rd_en;
    logic [2:0]  wr_idx, rd_idx;
    logic [3:0]  wr_strb;

    logic [15:0] PRDATA16, wr_data16;
    logic        PREADY16, PSLVERR16, wr_en16, rd_en16;
    logic [2:0]  wr_idx16, rd_idx16;
    logic [1:0]  wr_strb16;

    rsp_t rsp_q[$];
    rsp_t rsp16_q[$];
    stb_t stb_q[$];
    stb_t stb16_q[$];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rd_lat = -1;
    logic [31:0] rd_dat = '0;

    apb_slave_regif dut (
        .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    apb_slave_regif #(.DATA_WIDTH(16), .WAIT_STATES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .PSEL(PSEL16), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA[15:0]), .PSTRB(PSTRB[1:0]), .PRDATA(PRDATA16), .PREADY(PREADY16),
        .PSLVERR(PSLVERR16), .wr_en(wr_en16), .wr_idx(wr_idx16), .wr_data(wr_data16), .wr_strb(wr_strb16),
        .rd_en(rd_en16), .rd_idx(rd_idx16), .rd_data(16'h0), .rd_valid(1'b0)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Back-end model: answers a read strobe rd_lat cycles later, then keeps rd_valid up one
    // more cycle with different data, which the DUT must ignore once it has left WAIT
    initial forever begin
        @(negedge clk);
        if (rd_en && rd_lat >= 0) begin
            repeat (rd_lat) @(negedge clk);
            rd_valid = 1'b1;
            rd_data  = rd_dat;
            @(negedge clk);
            rd_data  = ~rd_dat;
            @(negedge clk);
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    end

    // Response monitor, 32-bit instance
    always @(negedge clk) begin
        rsp_t e;
        if (PREADY) begin
            if (rsp_q.size() == 0) chk("unexpected_pready", 1, 0);
            else begin
                e = rsp_q.pop_front();
                chk("pready_cycle", cyc, e.cyc);
                chk("pslverr", PSLVERR, e.err);
                chk("prdata", PRDATA, e.data);
            end
        end else chk("idle_resp_zero", {PSLVERR, PRDATA}, 0);
    end

    // Response monitor, 16-bit instance
    always @(negedge clk) begin
        rsp_t e;
        if (PREADY16) begin
            if (rsp16_q.size() == 0) chk("unexpected_pready16", 1, 0);
            else begin
                e = rsp16_q.pop_front();
                chk("pready16_cycle", cyc, e.cyc);
                chk("pslverr16", PSLVERR16, e.err);
                chk("prdata16", PRDATA16, e.data);
            end
        end
    end

    // Strobe monitor, 32-bit instance
    always @(negedge clk) begin
        stb_t s;
        if (wr_en || rd_en) begin
            if (stb_q.size() == 0) chk("unexpected_strobe", {wr_en, rd_en}, 0);
            else begin
                s = stb_q.pop_front();
                chk("strobe_cycle", cyc, s.cyc);
                chk("strobe_kind", {wr_en, rd_en}, {s.wr, !s.wr});
                if (s.wr) begin
                    chk("wr_idx", wr_idx, s.idx);
                    chk("wr_data", wr_data, s.data);
                    chk("wr_strb", wr_strb, s.strb);
                end else chk("rd_idx", rd_idx, s.idx);
            end
        end
    end

    // Strobe monitor, 16-bit instance
    always @(negedge clk) begin
        stb_t s;
        if (wr_en16 || rd_en16) begin
            if (stb16_q.size() == 0) chk("unexpected_strobe16", {wr_en16, rd_en16}, 0);
            else begin
                s = stb16_q.pop_front();
                chk("strobe16_cycle", cyc, s.cyc);
                chk("strobe16_kind", {wr_en16, rd_en16}, {s.wr, !s.wr});
                chk("wr_idx16", wr_idx16, s.idx);
                chk("wr_data16", wr_data16, s.data);
                chk("wr_strb16", wr_strb16, s.strb);
            end
        end
    end

    // One APB transfer: setup in T0, strobe expected in T0+1, PREADY expected in T0+lat
    task automatic xfer(input bit d16, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input int rlat, input logic [31:0] rdat,
                        input bit stb, input int idx, input int lat, input logic err,
                        input logic [31:0] edata, input bit abort);
        int t0;
        bit seen;
        @(posedge clk); #1;
        rd_lat = rlat;
        rd_dat = rdat;
        PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb; PENABLE = 1'b0;
        if (d16) PSEL16 = 1'b1; else PSEL = 1'b1;
        t0 = cyc;
        if (stb && d16) stb16_q.push_back('{t0 + 1, wr, idx, wr ? wd : 32'h0, wr ? strb : 4'h0});
        if (stb && !d16) stb_q.push_back('{t0 + 1, wr, idx, wr ? wd : 32'h0, wr ? strb : 4'h0});
        if (!abort && d16) rsp16_q.push_back('{t0 + lat, edata, err});
        if (!abort && !d16) rsp_q.push_back('{t0 + lat, edata, err});
        @(posedge clk); #1;
        if (abort) begin
            PSEL = 1'b0; PSEL16 = 1'b0;
            repeat (4) @(posedge clk);
        end else begin
            PENABLE = 1'b1;
            seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                seen = d16 ? PREADY16 : PREADY;
            end
            if (!seen) chk("pready_timeout", 0, 1);
            @(posedge clk); #1;
            PSEL = 1'b0; PSEL16 = 1'b0; PENABLE = 1'b0;
        end
    endtask

    initial begin
        int t0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_bus", {PREADY, PSLVERR, PRDATA}, 0);
        chk("reset_backend", {wr_en, wr_idx, wr_data, wr_strb, rd_en, rd_idx}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        //   d16 wr addr   wdata         strb rlat rdata          stb idx lat err edata          abort
        xfer(0, 1, 8'h04, 32'hDEADBEEF, 4'hF, -1, 32'h0,          1, 1,  2,  0, 32'h0,          0);
        xfer(0, 0, 8'h08, 32'h0,        4'h0,  3, 32'h12345678,   1, 2,  5,  0, 32'h12345678,   0);
        xfer(0, 0, 8'h20, 32'h0,        4'h0,  0, 32'h55555555,   0, 0,  2,  1, 32'h0,          0);
        xfer(0, 0, 8'h0C, 32'h0,        4'h0, -1, 32'h0,          1, 3, 17,  1, 32'h0,          0);
        xfer(0, 0, 8'h1C, 32'h0,        4'h0,  0, 32'hCAFEF00D,   1, 7,  2,  0, 32'hCAFEF00D,   0);
        xfer(0, 1, 8'h10, 32'h11111111, 4'h0, -1, 32'h0,          0, 4,  2,  0, 32'h0,          0);
        xfer(0, 1, 8'h40, 32'h22222222, 4'hF, -1, 32'h0,          0, 0,  2,  1, 32'h0,          0);
        xfer(0, 0, 8'h0B, 32'h0,        4'h0,  1, 32'hA5A55A5A,   1, 2,  3,  0, 32'hA5A55A5A,   0);
        xfer(0, 1, 8'h14, 32'h89ABCDEF, 4'hC, -1, 32'h0,          1, 5,  2,  0, 32'h0,          0);
        xfer(0, 1, 8'h18, 32'h0BADF00D, 4'h3, -1, 32'h0,          1, 6,  0,  0, 32'h0,          1);
        // Reset asserted while a read waits for rd_valid
        @(posedge clk); #1;
        rd_lat = -1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0C;
        t0 = cyc;
        stb_q.push_back('{t0 + 1, 1'b0, 3, 32'h0, 4'h0});
        @(posedge clk); #1 PENABLE = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midreset_bus", {PREADY, PSLVERR, PRDATA}, 0);
        chk("midreset_backend", {wr_en, wr_idx, wr_data, wr_strb, rd_en, rd_idx}, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        xfer(0, 0, 8'h00, 32'h0,        4'h0,  0, 32'h0F0F0F0F,   1, 0,  2,  0, 32'h0F0F0F0F,   0);
        xfer(1, 1, 8'h06, 32'h0000BEEF, 4'h2, -1, 32'h0,          1, 3,  4,  0, 32'h0,          0);
        xfer(1, 0, 8'h10, 32'h0,        4'h0, -1, 32'h0,          0, 0,  2,  1, 32'h0,          0);
        repeat (5) @(posedge clk);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("rsp16_q_drained", rsp16_q.size(), 0);
        chk("stb_q_drained", stb_q.size(), 0);
        chk("stb16_q_drained", stb16_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
